// File: rtl/elevator_pkg.sv
// Shared floor types and the door-service state encoding for the elevator call panel.
package elevator_pkg;

    typedef logic [1:0] floor_t;

    localparam floor_t FLOOR_0 = 2'd0;
    localparam floor_t FLOOR_1 = 2'd1;
    localparam floor_t FLOOR_2 = 2'd2;
    localparam floor_t FLOOR_3 = 2'd3;

    localparam int NUM_FLOORS = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SETTLE     = 2'd1,
        DOOR_OPEN  = 2'd2,
        DOOR_CLOSE = 2'd3
    } door_state_t;

endpackage

// File: rtl/call_input_conditioner.sv
// One floor-call button: 2-flop synchronizer, optional stable-high filter, rising-edge pulse.
// CALL_DEBOUNCE_EN enables the DEBOUNCE_CYCLES stable-high filter.
module call_input_conditioner
`ifdef CALL_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic level;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef CALL_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] stable_cnt;
    logic            filt;

    // Any low sample restarts the run; the filter rises after DEBOUNCE_CYCLES high samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_cnt <= '0;
            filt       <= 1'b0;
        end else if (!sync2) begin
            stable_cnt <= '0;
            filt       <= 1'b0;
        end else if (stable_cnt == DB_LAST) begin
            filt       <= 1'b1;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= 1'b0;
        else       prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/elevator_call_panel.sv
// Latches floor calls, drives the controller request vector and sequences door service on arrival.
// CALL_DEBOUNCE_EN adds a stable-high filter on every call button.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES  = 8,
    parameter int CLOSE_CYCLES = 2
`ifdef CALL_DEBOUNCE_EN
   ,parameter int DEBOUNCE_CYCLES = 4
`endif
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  floor_t                current_floor,
    input  logic                  moving,
    output logic [NUM_FLOORS-1:0] request,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  arrived_valid,
    output floor_t                arrived_floor,
    output door_state_t           fsm_state
);

    localparam int CNT_MAX = (DOOR_CYCLES > CLOSE_CYCLES) ? DOOR_CYCLES : CLOSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD  = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(CLOSE_CYCLES - 1);

    logic [NUM_FLOORS-1:0] rise;
    door_state_t           state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [NUM_FLOORS-1:0] pending_next;
    logic                  arrived_valid_next;
    floor_t                arrived_floor_next;
    logic                  hold;

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_cond
        call_input_conditioner
`ifdef CALL_DEBOUNCE_EN
            #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
        u_cond (
            .clk   (clk),
            .reset (reset),
            .btn   (call_btn[i]),
            .rise  (rise[i])
        );
    end

    // The car must stay put while a floor is in service or about to be.
    assign hold      = (state != IDLE) || (!moving && pending[current_floor]);
    assign request   = hold ? '0 : pending;
    assign door_open = (state == DOOR_OPEN);
    assign fsm_state = state;

    always_comb begin
        state_next         = state;
        cnt_next           = cnt;
        pending_next       = pending | rise;
        arrived_valid_next = 1'b0;
        arrived_floor_next = arrived_floor;
        case (state)
            IDLE: begin
                if (!moving && pending[current_floor]) state_next = SETTLE;
            end
            SETTLE: begin
                if (moving) begin
                    state_next = IDLE;
                end else begin
                    state_next                  = DOOR_OPEN;
                    pending_next[current_floor] = 1'b0;
                    arrived_valid_next          = 1'b1;
                    arrived_floor_next          = current_floor;
                    cnt_next                    = DOOR_LOAD;
                end
            end
            DOOR_OPEN: begin
                // A local press while open only extends the door time.
                pending_next[current_floor] = pending[current_floor];
                if (rise[current_floor]) begin
                    cnt_next = DOOR_LOAD;
                end else if (cnt == '0) begin
                    cnt_next   = CLOSE_LOAD;
                    state_next = DOOR_CLOSE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DOOR_CLOSE: begin
                if (cnt == '0) state_next = IDLE;
                else           cnt_next   = cnt - 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            pending       <= '0;
            arrived_valid <= 1'b0;
            arrived_floor <= FLOOR_0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            pending       <= pending_next;
            arrived_valid <= arrived_valid_next;
            arrived_floor <= arrived_floor_next;
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel: vector table for a full remote service plus hand sequences.
module tb_elevator_call_panel;
    import elevator_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  call_btn;
    floor_t      current_floor;
    logic        moving;
    logic [3:0]  request;
    logic [3:0]  pending;
    logic        door_open;
    logic        arrived_valid;
    floor_t      arrived_floor;
    door_state_t fsm_state;

    int tests_run;
    int tests_failed;

    elevator_call_panel dut (
        .clk           (clk),
        .reset         (reset),
        .call_btn      (call_btn),
        .current_floor (current_floor),
        .moving        (moving),
        .request       (request),
        .pending       (pending),
        .door_open     (door_open),
        .arrived_valid (arrived_valid),
        .arrived_floor (arrived_floor),
        .fsm_state     (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  btn;
        logic [1:0]  floor;
        logic        mov;
        logic [3:0]  req;
        logic [3:0]  pend;
        logic        door;
        logic        av;
        logic [1:0]  af;
        door_state_t st;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, then look at outputs just after the next rising edge.
    task automatic step(input logic [3:0] b, input logic [1:0] f, input logic m);
        @(negedge clk);
        call_btn      = b;
        current_floor = f;
        moving        = m;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] req, input logic [3:0] pend,
                           input logic door, input logic av, input door_state_t st);
        chk({tag, ".request"},       32'(request),       32'(req));
        chk({tag, ".pending"},       32'(pending),       32'(pend));
        chk({tag, ".door_open"},     32'(door_open),     32'(door));
        chk({tag, ".arrived_valid"}, 32'(arrived_valid), 32'(av));
        chk({tag, ".state"},         32'(fsm_state),     32'(st));
    endtask

    initial begin
        int door_cnt;
        logic [3:0] req_seen;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        call_btn     = '0;
        current_floor = 2'd0;
        moving       = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset_hold", 4'b0000, 4'b0000, 1'b0, 1'b0, IDLE);
        chk("reset_hold.arrived_floor", 32'(arrived_floor), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(4'b0000, 2'd0, 1'b0);
        chk_all("after_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, IDLE);

        // Remote call to floor 2 from floor 0: full service sequence.
        vecs[0]  = '{4'b0100, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, IDLE};
        vecs[1]  = '{4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, IDLE};
        vecs[2]  = '{4'b0000, 2'd0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 2'd0, IDLE};
        vecs[3]  = '{4'b0000, 2'd1, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 2'd0, IDLE};
        vecs[4]  = '{4'b0000, 2'd2, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 2'd0, IDLE};
        vecs[5]  = '{4'b0000, 2'd2, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 2'd0, SETTLE};
        vecs[6]  = '{4'b0000, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, DOOR_OPEN};
        for (int i = 7; i < 14; i++)
            vecs[i] = '{4'b0000, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, DOOR_OPEN};
        vecs[14] = '{4'b0000, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, DOOR_CLOSE};
        vecs[15] = '{4'b0000, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, DOOR_CLOSE};
        vecs[16] = '{4'b0000, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, IDLE};
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].btn, vecs[i].floor, vecs[i].mov);
            chk_all($sformatf("remote_v%0d", i), vecs[i].req, vecs[i].pend,
                    vecs[i].door, vecs[i].av, vecs[i].st);
            chk($sformatf("remote_v%0d.arrived_floor", i), 32'(arrived_floor), 32'(vecs[i].af));
        end

        // Local call at floor 0: request never asserted, door opens in place.
        step(4'b0001, 2'd0, 1'b0);
        step(4'b0000, 2'd0, 1'b0);
        step(4'b0000, 2'd0, 1'b0);
        chk_all("local_latched", 4'b0000, 4'b0001, 1'b0, 1'b0, IDLE);
        step(4'b0000, 2'd0, 1'b0);
        chk_all("local_settle", 4'b0000, 4'b0001, 1'b0, 1'b0, SETTLE);
        step(4'b0000, 2'd0, 1'b0);
        chk_all("local_open", 4'b0000, 4'b0000, 1'b1, 1'b1, DOOR_OPEN);
        chk("local_open.arrived_floor", 32'(arrived_floor), 32'd0);
        door_cnt = 0;
        req_seen = '0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 2'd0, 1'b0);
            if (door_open) door_cnt++;
            req_seen = req_seen | request;
        end
        chk("local_door_cycles", 32'(door_cnt + 1), 32'd8);
        chk("local_no_request", 32'(req_seen), 32'd0);
        chk("local_end_state", 32'(fsm_state), 32'(IDLE));

        // Door open at floor 2: a local press extends the door, a remote press waits masked.
        step(4'b0100, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        chk_all("extend_open", 4'b0000, 4'b0000, 1'b1, 1'b1, DOOR_OPEN);
        step(4'b1100, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        chk_all("extend_reload", 4'b0000, 4'b1000, 1'b1, 1'b0, DOOR_OPEN);
        door_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 2'd2, 1'b0);
            if (door_open) door_cnt++;
        end
        chk("extend_door_cycles", 32'(door_cnt + 1), 32'd8);
        chk_all("extend_after_close", 4'b1000, 4'b1000, 1'b0, 1'b0, IDLE);
        step(4'b0000, 2'd3, 1'b1);
        chk("extend_moving_req", 32'(request), 32'b1000);
        step(4'b0000, 2'd3, 1'b0);
        chk_all("extend_arrive3", 4'b0000, 4'b1000, 1'b0, 1'b0, SETTLE);
        step(4'b0000, 2'd3, 1'b0);
        chk_all("extend_open3", 4'b0000, 4'b0000, 1'b1, 1'b1, DOOR_OPEN);
        chk("extend_open3.arrived_floor", 32'(arrived_floor), 32'd3);

        // Reset in the fourth door-open cycle with calls 0 and 3 still pending.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step(4'b1101, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        chk_all("abort_open1", 4'b0000, 4'b1001, 1'b1, 1'b1, DOOR_OPEN);
        step(4'b0000, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        step(4'b0000, 2'd2, 1'b0);
        chk_all("abort_open4", 4'b0000, 4'b1001, 1'b1, 1'b0, DOOR_OPEN);
        reset = 1'b1;
        #1;
        chk_all("abort_in_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, IDLE);
        @(negedge clk);
        reset = 1'b0;
        step(4'b0000, 2'd2, 1'b0);
        chk_all("abort_released", 4'b0000, 4'b0000, 1'b0, 1'b0, IDLE);

`ifdef CALL_DEBOUNCE_EN
        // A 2-cycle pulse is filtered out; a 6-cycle press lands 6 edges after it starts.
        step(4'b0010, 2'd0, 1'b0);
        step(4'b0010, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++) step(4'b0000, 2'd0, 1'b0);
        chk("debounce_short_pulse", 32'(pending), 32'd0);
        for (int i = 0; i < 6; i++) step(4'b0010, 2'd0, 1'b0);
        chk("debounce_before", 32'(pending), 32'd0);
        step(4'b0000, 2'd0, 1'b0);
        chk("debounce_latched", 32'(pending), 32'b0010);
        chk("debounce_request", 32'(request), 32'b0010);
`else
        // A held button registers once, two edges after it goes high.
        step(4'b0010, 2'd0, 1'b0);
        step(4'b0010, 2'd0, 1'b0);
        chk("held_edge2", 32'(pending), 32'd0);
        step(4'b0010, 2'd0, 1'b0);
        chk("held_latched", 32'(pending), 32'b0010);
        chk("held_request", 32'(request), 32'b0010);
        for (int i = 0; i < 4; i++) step(4'b0010, 2'd0, 1'b0);
        step(4'b0000, 2'd0, 1'b0);
        chk("held_single_call", 32'(pending), 32'b0010);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Request-side companion to the 4-floor elevator controller: conditions raw floor-call buttons, latches pending calls and drives the controller's one-hot request vector.
- Watches the controller's current_floor/moving outputs to detect arrival, run the door open/close sequence and clear served calls.
- Masks requests while a floor is being served, so the car holds until the door has closed.

Parameters:
- DOOR_CYCLES, 8, cycles door_open stays asserted per service (min 1).
- CLOSE_CYCLES, 2, cycles spent in DOOR_CLOSE before returning to IDLE (min 1).
- DEBOUNCE_CYCLES, 4, stable-high cycles required when CALL_DEBOUNCE_EN is defined (min 1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- call_btn  in  4  raw asynchronous floor-call buttons, active-high, bit i = floor i.
- current_floor  in  2  floor from the elevator controller.
- moving  in  1  controller moving flag (registered; high one cycle after a floor change).
- request  out  4  one-hot-or-multi call vector to the controller.
- pending  out  4  latched unserved calls.
- door_open  out  1  door open indicator.
- arrived_valid  out  1  single-cycle pulse when a call is served.
- arrived_floor  out  2  floor served; valid with arrived_valid, holds last value otherwise.

Behaviour:
- Reset (async): pending=0, door_open=0, arrived_valid=0, arrived_floor=0, FSM=IDLE, counter=0, synchronizers=0. Reset mid-operation aborts any door cycle immediately; all pending calls are lost.
- Input path per button: 2-flop synchronizer, then rising-edge detect against a third flop. A button high at edge N sets pending[i] at edge N+2. A held button yields one call.
- Pending set/clear: set on edge detect; cleared only on service. If set and clear hit the same bit in the same cycle, clear wins.
- hold = (state != IDLE) || (!moving && pending[current_floor]).
- request = hold ? 4'b0000 : pending (combinational).
- FSM states:
  - IDLE: if !moving && pending[current_floor], go to SETTLE.
  - SETTLE (1 cycle): if moving=1, return to IDLE. Otherwise go to DOOR_OPEN, clear pending[current_floor], pulse arrived_valid, set arrived_floor=current_floor, load counter=DOOR_CYCLES-1.
  - DOOR_OPEN: door_open=1. Counter decrements each cycle. A new press of call_btn[current_floor] reloads the counter to DOOR_CYCLES-1 and is not latched. At counter 0, load CLOSE_CYCLES-1 and go to DOOR_CLOSE.
  - DOOR_CLOSE: door_open=0. Presses on any floor, including the current floor, are latched. At counter 0, go to IDLE. If pending[current_floor] is set again, IDLE re-enters SETTLE, so the door reopens.
- Calls for other floors are latched in every state but stay masked from request until IDLE with no local call pending.
- Counter width: $clog2 of max(DOOR_CYCLES, CLOSE_CYCLES)+1. No wrap; saturates at 0.

Optional Feature:
- Macro: CALL_DEBOUNCE_EN.
- Defined: each synchronized button must stay high for DEBOUNCE_CYCLES consecutive cycles before the edge detector sees it. This adds DEBOUNCE_CYCLES cycles of latency; shorter pulses are discarded.
- Undefined: no filter; any pulse caught by the synchronizer (≥1 cycle) registers a call.

Decomposition:
- Package elevator_pkg holds:
  - floor_t (2-bit) and FLOOR_0..FLOOR_3.
  - NUM_FLOORS=4.
  - door FSM enum {IDLE, SETTLE, DOOR_OPEN, DOOR_CLOSE}.
- Sub-module call_input_conditioner: 1-bit synchronizer, optional debounce and rising-edge pulse output, instantiated 4×.

Test Plan:
1. Assert reset, then deassert → request=0000, pending=0000, door_open=0, arrived_valid=0; FSM in IDLE.
2. Car idle at floor 0, one-cycle pulse on call_btn[2] (macro off) → pending=0100 at edge N+2 and request=0100. Controller moves to floor 2 (moving high 1 cycle). When moving falls, request=0000, arrived_valid pulses with arrived_floor=2, door_open high exactly 8 cycles, then 2 close cycles, pending=0000.
3. Car idle at floor 0, press call_btn[0] → request stays 0000 (hold), car does not move, door opens, arrived_floor=0.
4. Door open at floor 2 (counter=3): press btn[3] and btn[2] together → pending=1000 but request=0000; door counter reloads to 7, giving 8 more open cycles. After close, request=1000 and the car goes to floor 3.
5. Assert reset in the 4th DOOR_OPEN cycle with pending=1001 → door_open=0 and pending=0000 immediately; after release, FSM is IDLE and request=0000.
6. CALL_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=4: a 2-cycle pulse on btn[1] is ignored (pending stays 0000); a 6-cycle pulse sets pending=0010 four cycles later than with the macro off.
